// File: rtl/cra_seq_ctrl.sv
// Multi-cycle carry-ripple adder: an n-bit sum computed through one w-bit slice,
// reused over n/w cycles, with valid/ready handshakes on both sides.
module cra_seq_ctrl #(
    parameter int n = 256,
    parameter int w = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         cin,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] s,
    output logic         cout,
    output logic         busy
);

    localparam int k  = n / w;
    localparam int CW = $clog2(k);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q;
    logic [n-1:0]  a_q;
    logic [n-1:0]  b_q;
    logic [n-1:0]  s_q;
    logic          carry_q;
    logic          cout_q;
    logic [CW-1:0] cnt_q;
    logic [w:0]    slice_d;

    // The one physical ripple slice, steered by the slice counter.
    always_comb begin
        slice_d = {1'b0, a_q[cnt_q*w +: w]}
                + {1'b0, b_q[cnt_q*w +: w]}
                + {{w{1'b0}}, carry_q};
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others; blocking here would chain them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the operand and sum registers are reset as well, so an
            // aborted operation can never leave a partial result visible on s.
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        s_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    s_q[cnt_q*w +: w] <= slice_d[w-1:0];
                    carry_q           <= slice_d[w];
                    cnt_q             <= cnt_q + CW'(1);
                    if (cnt_q == CW'(k - 1)) begin
                        cout_q  <= slice_d[w];
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake outputs come from the registered state only.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_cra_seq_ctrl.sv
// Scoreboard bench for cra_seq_ctrl: 256/32 main instance plus 64/16 and 256/128
// instances sharing one stimulus bus.
module tb_cra_seq_ctrl;

    localparam int N = 256;
    localparam int W = 32;
    localparam int K = N / W;

    typedef struct {
        logic [255:0] s;
        logic         c;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [N-1:0] a, b, s;

    logic         alt_valid, alt_ready, alt_cin;
    logic [255:0] alt_a, alt_b;
    logic         in_ready64, out_valid64, cout64, busy64;
    logic [63:0]  s64;
    logic         in_ready2, out_valid2, cout2, busy2;
    logic [255:0] s2;

    always #5 clk = ~clk;

    cra_seq_ctrl #(.n(N), .w(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cin(cin),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .s(s),
        .cout(cout), .busy(busy)
    );

    cra_seq_ctrl #(.n(64), .w(16)) dut64 (
        .clk(clk), .rst(rst), .in_valid(alt_valid), .in_ready(in_ready64), .cin(alt_cin),
        .a(alt_a[63:0]), .b(alt_b[63:0]), .out_valid(out_valid64), .out_ready(alt_ready),
        .s(s64), .cout(cout64), .busy(busy64)
    );

    cra_seq_ctrl #(.n(256), .w(128)) dut2 (
        .clk(clk), .rst(rst), .in_valid(alt_valid), .in_ready(in_ready2), .cin(alt_cin),
        .a(alt_a), .b(alt_b), .out_valid(out_valid2), .out_ready(alt_ready),
        .s(s2), .cout(cout2), .busy(busy2)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   edges;
    res_t exp_r;
    res_t sb_q[$];
    res_t q64[$];
    res_t q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [256:0] act, input logic [256:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic res_t model(input logic [255:0] x, input logic [255:0] y, input logic c);
        logic [256:0] t;
        t = {1'b0, x} + {1'b0, y} + {256'd0, c};
        model.s = t[255:0];
        model.c = t[256];
    endfunction

    function automatic res_t model64(input logic [63:0] x, input logic [63:0] y, input logic c);
        logic [64:0] t;
        t = {1'b0, x} + {1'b0, y} + {64'd0, c};
        model64.s = {192'd0, t[63:0]};
        model64.c = t[64];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        case ($urandom_range(0, 7))
            0:       r = '1;
            1:       r = '0;
            default: for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        endcase
        return r;
    endfunction

    // Drives one operation into the main DUT; returns at the negedge after acceptance.
    task automatic start_op(input logic [255:0] x, input logic [255:0] y, input logic c);
        @(negedge clk);
        check("accept_ready", 257'(in_ready), 257'(1));
        a = x; b = y; cin = c; in_valid = 1'b1;
        sb_q.push_back(model(x, y, c));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        edges = 0;
    endtask

    task automatic finish_op();
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("done_valid", 257'(out_valid), 257'(1));
        check("latency", 257'(edges), 257'(K));
        if (sb_q.size() > 0) begin
            exp_r = sb_q.pop_front();
            check("sum", 257'(s), 257'(exp_r.s));
            check("cout", 257'(cout), 257'(exp_r.c));
        end
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_ready", 257'(in_ready), 257'(1));
        check("idle_valid", 257'(out_valid), 257'(0));
        check("s_hold", 257'(s), 257'(exp_r.s));
        check("cout_hold", 257'(cout), 257'(exp_r.c));
    endtask

    task automatic run_alt(input logic [255:0] x, input logic [255:0] y, input logic c);
        int   lat64, lat2;
        res_t e;
        @(negedge clk);
        check("alt_ready64", 257'(in_ready64), 257'(1));
        check("alt_ready2", 257'(in_ready2), 257'(1));
        alt_a = x; alt_b = y; alt_cin = c; alt_valid = 1'b1;
        q64.push_back(model64(x[63:0], y[63:0], c));
        q2.push_back(model(x, y, c));
        @(posedge clk);
        @(negedge clk);
        alt_valid = 1'b0;
        edges = 0; lat64 = -1; lat2 = -1;
        while ((lat64 < 0 || lat2 < 0) && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (out_valid64 && lat64 < 0 && q64.size() > 0) begin
                lat64 = edges;
                e = q64.pop_front();
                check("n64_sum", 257'(s64), 257'(e.s));
                check("n64_cout", 257'(cout64), 257'(e.c));
            end
            if (out_valid2 && lat2 < 0 && q2.size() > 0) begin
                lat2 = edges;
                e = q2.pop_front();
                check("k2_sum", 257'(s2), 257'(e.s));
                check("k2_cout", 257'(cout2), 257'(e.c));
            end
        end
        check("n64_latency", 257'(lat64), 257'(4));
        check("k2_latency", 257'(lat2), 257'(2));
        q64.delete();
        q2.delete();
        alt_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        alt_ready = 1'b0;
    endtask

    initial begin
        int issued, done_n, last_acc, acc, guard;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; a = '0; b = '0;
        alt_valid = 1'b0; alt_ready = 1'b0; alt_cin = 1'b0; alt_a = '0; alt_b = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 257'(in_ready), 257'(1));
        check("rst_out_valid", 257'(out_valid), 257'(0));
        check("rst_busy", 257'(busy), 257'(0));
        check("rst_s", 257'(s), 257'(0));
        check("rst_cout", 257'(cout), 257'(0));
        rst = 1'b0;

        // A single cin rippling through every slice.
        start_op('1, '0, 1'b1);
        finish_op();
        check("ripple_s", 257'(s), 257'(0));
        check("ripple_cout", 257'(cout), 257'(1));
        release_op();

        // Abort mid-RUN at cnt=3, then a clean operation.
        start_op('1, '0, 1'b0);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        check("mid_busy", 257'(busy), 257'(1));
        #2 rst = 1'b1;
        #1;
        check("abort_valid", 257'(out_valid), 257'(0));
        check("abort_s", 257'(s), 257'(0));
        check("abort_cout", 257'(cout), 257'(0));
        check("abort_ready", 257'(in_ready), 257'(1));
        check("abort_busy", 257'(busy), 257'(0));
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Carry across the slice 0/1 boundary, observed as slice 1 is written.
        start_op(256'hFFFF_FFFF, 256'd1, 1'b0);
        @(posedge clk); edges++; @(negedge clk);
        check("slice0_written", 257'(s), 257'(0));
        @(posedge clk); edges++; @(negedge clk);
        check("slice1_written", 257'(s), 257'(256'h1_0000_0000));
        finish_op();
        release_op();

        // Backpressure with operand pulses that must be ignored.
        start_op(rand256(), rand256(), 1'b1);
        finish_op();
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            a = rand256(); b = rand256(); cin = i[1];
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", 257'(out_valid), 257'(1));
            check("bp_ready", 257'(in_ready), 257'(0));
            check("bp_s", 257'(s), 257'(exp_r.s));
            check("bp_cout", 257'(cout), 257'(exp_r.c));
        end
        in_valid = 1'b0;
        release_op();
        repeat (2) @(negedge clk);
        check("bp_no_ghost", 257'(out_valid | busy), 257'(0));

        // Asynchronous reset while a result waits in DONE.
        start_op(rand256(), rand256(), 1'b0);
        finish_op();
        #2 rst = 1'b1;
        #1;
        check("done_rst_valid", 257'(out_valid), 257'(0));
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        issued = 0; done_n = 0; last_acc = -1; guard = 0;
        while (done_n < 1000 && guard < 1000 * (K + 2) + 100) begin
            @(negedge clk);
            guard++;
            if (out_valid) begin
                if (sb_q.size() > 0) begin
                    exp_r = sb_q.pop_front();
                    check("b2b_sum", 257'(s), 257'(exp_r.s));
                    check("b2b_cout", 257'(cout), 257'(exp_r.c));
                end
                done_n++;
            end
            if (in_ready) begin
                if (issued < 1000) begin
                    in_valid = 1'b1;
                    a = rand256(); b = rand256(); cin = 1'($urandom_range(0, 1));
                    sb_q.push_back(model(a, b, cin));
                    acc = cyc + 1;
                    if (last_acc >= 0) check("b2b_spacing", 257'(acc - last_acc), 257'(K + 2));
                    last_acc = acc;
                    issued++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_count", 257'(done_n), 257'(1000));
        in_valid = 1'b0;
        out_ready = 1'b0;

        // Other parameterisations: corners and random vectors.
        run_alt('0, '0, 1'b0);
        run_alt('1, '1, 1'b1);
        for (int i = 0; i < 4; i++) run_alt(rand256(), rand256(), 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cra_seq_ctrl.md
Name: cra_seq_ctrl

Overview:
- Multi-cycle sequencer for wide carry-ripple addition.
- Computes an N-bit sum plus carry through a single W-bit ripple slice, reused over N/W cycles.
- A registered carry chains the slices from one cycle to the next.
- Sits in front of consumers that trade latency for area versus the fully unrolled cra* adders.
- Valid/ready handshake on both input and output sides.

Parameters:
- n, 256: total operand width.
- w, 32: slice width added per cycle. n must be divisible by w; n/w >= 2.
- k, n/w: number of slices. Derived; not to be overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present on cin/a/b.
- in_ready  output  1  block can accept operands.
- cin  input  1  carry-in for slice 0.
- a  input  n  operand A.
- b  input  n  operand B.
- out_valid  output  1  s/cout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- s  output  n  sum.
- cout  output  1  carry-out of the top slice.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst=1, asynchronous, any state including mid-RUN):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - s=0; cout=0; internal a/b/carry registers=0; slice counter=0.
  - An in-flight operation is discarded with no partial result.
- States: IDLE, RUN, DONE. Outputs are decoded from registered state only; there is no combinational path from in_valid/out_ready to any output.
  - in_ready = (state==IDLE).
  - busy = (state==RUN).
  - out_valid = (state==DONE).
- IDLE:
  - On in_valid & in_ready: latch a and b, carry<=cin, cnt<=0, clear s to 0, go to RUN.
  - in_valid without acceptance has no effect.
- RUN, each cycle:
  - {c, sum} = a_q[cnt*w +: w] + b_q[cnt*w +: w] + carry, computed at w+1 bits.
  - s[cnt*w +: w] <= sum; carry <= c; cnt <= cnt+1.
  - When cnt==k-1: cout <= c and go to DONE.
  - Inputs a/b/cin/in_valid are ignored in RUN. in_ready=0.
- DONE:
  - out_valid=1. s and cout are held stable until the handshake.
  - On out_ready: go to IDLE. s and cout keep their values after leaving DONE; only out_valid drops.
  - Without out_ready, stay in DONE indefinitely (backpressure). New operands are not accepted.
- Latency: operands accepted at edge E; out_valid rises after edge E+k and is seen in the cycle following E+k.
- Throughput: one addition per k+2 cycles at minimum (accept, k RUN cycles, DONE, return to IDLE). No overlap of operations.
- Arithmetic:
  - Result equals (a + b + cin) mod 2^n.
  - cout equals bit n of the full (n+1)-bit sum.
  - Bit-exact against the combinational cra256bits for n=256.
- Boundary conditions:
  - Carry propagates across every slice boundary, including all-ones operands where a single cin ripples through all k slices.
  - in_valid held high continuously: the next operation is accepted only on return to IDLE.
  - out_ready already high on entering DONE: exactly one cycle in DONE.
  - rst asserted in DONE: out_valid drops immediately (asynchronously).

Test Plan:
- Reset mid-RUN: assert rst at cnt=3 -> out_valid=0, s=0, cout=0, in_ready=1 immediately. A fresh operation afterwards completes correctly.
- Full ripple: a=2^256-1, b=0, cin=1 -> after 8 RUN cycles, s=0 and cout=1, out_valid asserted at latency k=8.
- Slice-boundary carry: a=0x0000_0000_FFFF_FFFF (zero-extended), b=1, cin=0 -> s=0x1_0000_0000, cout=0. Also check that intermediate slice 1 is written in the cycle with cnt=1.
- Backpressure: out_ready=0 for 20 cycles -> out_valid stays 1, s/cout stable, in_ready=0. Pulsing in_valid with new operands during this window has no effect. Then out_ready=1 -> IDLE next cycle.
- Back-to-back: in_valid and out_ready tied high, 1000 random operand triples -> each result matches the reference model (a+b+cin), with an accept-to-accept spacing of k+2=10 cycles.
- Parameter sweep: n=64, w=16 and n=256, w=128 (k=2) -> random and corner vectors (0+0+0, max+max+1) match the model; latency equals k.
